// File: rtl/xbar_out_stage_pkg.sv
// rtl/xbar_out_stage_pkg.sv - shared constants, error types and helpers for the crossbar output stage
package pronoc_pkg;

    localparam int Fw    = 36;
    localparam int V     = 4;
    localparam int B     = 4;
    localparam int CRD_W = $clog2(B + 1);

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_UNDERFLOW,
        ERR_OVERFLOW,
        ERR_VC_ENC
    } err_type_e;

    function automatic err_type_e classify_err(input logic uf, input logic of, input logic enc);
        if (uf)  return ERR_UNDERFLOW;
        if (of)  return ERR_OVERFLOW;
        if (enc) return ERR_VC_ENC;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/xbar_out_stage_if.sv
// rtl/xbar_out_stage_if.sv - crossbar-side and link-side bundle of the output stage
interface xbar_out_stage_if #(parameter int P = 5);
    import pronoc_pkg::*;

    logic [P*Fw-1:0] flit_in_all;
    logic [P-1:0]    flit_in_wr_all;
    logic [P*V-1:0]  flit_in_vc_all;
    logic [P*V-1:0]  credit_in_all;
    logic [P*Fw-1:0] flit_out_all;
    logic [P-1:0]    flit_out_wr_all;
    logic [P*V-1:0]  flit_out_vc_all;
    logic [P*V-1:0]  credit_avail_all;
    logic [P*V-1:0]  credit_full_all;
    logic [P-1:0]    err_all;

    modport master (
        output flit_in_all, flit_in_wr_all, flit_in_vc_all, credit_in_all,
        input  flit_out_all, flit_out_wr_all, flit_out_vc_all,
        input  credit_avail_all, credit_full_all, err_all
    );

    modport slave (
        input  flit_in_all, flit_in_wr_all, flit_in_vc_all, credit_in_all,
        output flit_out_all, flit_out_wr_all, flit_out_vc_all,
        output credit_avail_all, credit_full_all, err_all
    );

endinterface

// File: rtl/xbar_out_stage_credit_counter.sv
// rtl/xbar_out_stage_credit_counter.sv - one saturating per-(port, VC) downstream credit counter
module out_vc_credit_counter
    import pronoc_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic consume,
    input  logic ret,
    output logic avail,
    output logic full,
    output logic underflow,
    output logic overflow
);

    logic [CRD_W-1:0] cnt_q, cnt_d;

    // Simultaneous consume and return cancel, so bounds only matter for a lone event.
    always_comb begin
        cnt_d     = cnt_q;
        underflow = 1'b0;
        overflow  = 1'b0;
        if (consume && !ret) begin
            if (cnt_q == '0) underflow = 1'b1;
            else             cnt_d = cnt_q - CRD_W'(1);
        end else if (ret && !consume) begin
            if (cnt_q == CRD_W'(B)) overflow = 1'b1;
            else                    cnt_d = cnt_q + CRD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= CRD_W'(B);
        else        cnt_q <= cnt_d;
    end

    assign avail = (cnt_q != '0);
    assign full  = (cnt_q == CRD_W'(B));

endmodule

// File: rtl/xbar_out_stage.sv
// rtl/xbar_out_stage.sv - registered crossbar output stage with credit tracking; optional PRONOC_XBAR_OUT_CRD_CHK_EN
module xbar_out_stage
    import pronoc_pkg::*;
#(
    parameter int P = 5
) (
    input  logic             clk,
    input  logic             reset,
    xbar_out_stage_if.slave  bus
);

    logic [P*Fw-1:0] flit_q, flit_d;
    logic [P-1:0]    wr_q;
    logic [P*V-1:0]  vc_q;
    logic [P*V-1:0]  avail_w, full_w, uf_w, of_w;

    // Flit data only toggles on a real write; wr/vc always follow the crossbar.
    always_comb begin
        flit_d = flit_q;
        for (int i = 0; i < P; i++) begin
            if (bus.flit_in_wr_all[i]) flit_d[i*Fw +: Fw] = bus.flit_in_all[i*Fw +: Fw];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flit_q <= '0;
            wr_q   <= '0;
            vc_q   <= '0;
        end else begin
            flit_q <= flit_d;
            wr_q   <= bus.flit_in_wr_all;
            vc_q   <= bus.flit_in_vc_all;
        end
    end

    assign bus.flit_out_all    = flit_q;
    assign bus.flit_out_wr_all = wr_q;
    assign bus.flit_out_vc_all = vc_q;

    for (genvar i = 0; i < P; i++) begin : g_port
        for (genvar v = 0; v < V; v++) begin : g_vc
            out_vc_credit_counter u_cnt (
                .clk       (clk),
                .reset     (reset),
                .consume   (bus.flit_in_wr_all[i] & bus.flit_in_vc_all[i*V+v]),
                .ret       (bus.credit_in_all[i*V+v]),
                .avail     (avail_w[i*V+v]),
                .full      (full_w[i*V+v]),
                .underflow (uf_w[i*V+v]),
                .overflow  (of_w[i*V+v])
            );
        end
    end

    assign bus.credit_avail_all = avail_w;
    assign bus.credit_full_all  = full_w;

`ifdef PRONOC_XBAR_OUT_CRD_CHK_EN
    logic [P-1:0] err_q, err_d;

    // A written flit must name exactly one VC; anything else is an encoding error.
    always_comb begin
        err_d = err_q;
        for (int i = 0; i < P; i++) begin
            if (classify_err(|uf_w[i*V +: V], |of_w[i*V +: V],
                             bus.flit_in_wr_all[i] && ($countones(bus.flit_in_vc_all[i*V +: V]) != 1))
                != ERR_NONE)
                err_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= '0;
        else        err_q <= err_d;
    end

    assign bus.err_all = err_q;
`else
    logic unused_chk;
    assign unused_chk  = ^{uf_w, of_w};
    assign bus.err_all = '0;
`endif

endmodule

// File: tb/tb_xbar_out_stage.sv
// tb/tb_xbar_out_stage.sv - self-checking bench for xbar_out_stage (table vectors plus random vs model)
module tb_xbar_out_stage;
    import pronoc_pkg::*;

    localparam int P = 5;
`ifdef PRONOC_XBAR_OUT_CRD_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    xbar_out_stage_if #(.P(P)) bus ();

    xbar_out_stage #(.P(P)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    int              m_cnt [P][V];
    logic [P-1:0]    m_err;
    logic [P-1:0]    m_wr;
    logic [P*V-1:0]  m_vc;
    logic [P*Fw-1:0] m_flit;

    typedef struct {
        int           port;
        logic         wr;
        logic [V-1:0] vc;
        logic [V-1:0] crd;
        logic [Fw-1:0] flit;
        logic [V-1:0] e_avail;
        logic [V-1:0] e_full;
        logic         e_err;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < P; p++)
            for (int v = 0; v < V; v++) m_cnt[p][v] = B;
        m_err = '0; m_wr = '0; m_vc = '0; m_flit = '0;
    endtask

    task automatic model_step(input logic [P-1:0] wr, input logic [P*V-1:0] vc,
                              input logic [P*V-1:0] crd, input logic [P*Fw-1:0] fl);
        for (int p = 0; p < P; p++) begin
            int ones;
            ones = 0;
            for (int v = 0; v < V; v++) begin
                bit use_c, give_c;
                use_c  = wr[p] && vc[p*V+v];
                give_c = crd[p*V+v];
                ones  += vc[p*V+v] ? 1 : 0;
                if (use_c && !give_c) begin
                    if (m_cnt[p][v] == 0) m_err[p] = 1'b1;
                    else m_cnt[p][v] -= 1;
                end else if (give_c && !use_c) begin
                    if (m_cnt[p][v] == B) m_err[p] = 1'b1;
                    else m_cnt[p][v] += 1;
                end
            end
            if (wr[p] && ones != 1) m_err[p] = 1'b1;
            if (wr[p]) m_flit[p*Fw +: Fw] = fl[p*Fw +: Fw];
        end
        m_wr = wr;
        m_vc = vc;
    endtask

    task automatic check_all(input string tag);
        logic [P*V-1:0] ea, ef;
        for (int p = 0; p < P; p++)
            for (int v = 0; v < V; v++) begin
                ea[p*V+v] = (m_cnt[p][v] > 0);
                ef[p*V+v] = (m_cnt[p][v] == B);
            end
        chk({tag, ".wr"},    bus.flit_out_wr_all,  m_wr);
        chk({tag, ".vc"},    bus.flit_out_vc_all,  m_vc);
        chk({tag, ".flit"},  bus.flit_out_all,     m_flit);
        chk({tag, ".avail"}, bus.credit_avail_all, ea);
        chk({tag, ".full"},  bus.credit_full_all,  ef);
        chk({tag, ".err"},   bus.err_all,          CHK ? m_err : '0);
    endtask

    // Drive one cycle of crossbar inputs, let the edge pass, then sample 1ns later.
    task automatic cycle(input logic [P-1:0] wr, input logic [P*V-1:0] vc,
                         input logic [P*V-1:0] crd, input logic [P*Fw-1:0] fl);
        bus.flit_in_wr_all = wr;
        bus.flit_in_vc_all = vc;
        bus.credit_in_all  = crd;
        bus.flit_in_all    = fl;
        @(posedge clk);
        model_step(wr, vc, crd, fl);
        #1;
    endtask

    initial begin
        logic [P-1:0]    wr;
        logic [P*V-1:0]  vc, crd;
        logic [P*Fw-1:0] fl;
        logic [63:0]     r;

        tbl[0]  = '{2, 1'b1, 4'b0010, 4'b0000, 36'h0A5, 4'b1111, 4'b1101, 1'b0};
        tbl[1]  = '{2, 1'b1, 4'b0010, 4'b0000, 36'h0A6, 4'b1111, 4'b1101, 1'b0};
        tbl[2]  = '{2, 1'b1, 4'b0010, 4'b0000, 36'h0A7, 4'b1111, 4'b1101, 1'b0};
        tbl[3]  = '{2, 1'b1, 4'b0010, 4'b0000, 36'h0A8, 4'b1101, 4'b1101, 1'b0};
        tbl[4]  = '{2, 1'b1, 4'b0010, 4'b0010, 36'h0A9, 4'b1101, 4'b1101, 1'b0};
        tbl[5]  = '{2, 1'b0, 4'b0000, 4'b0010, 36'h0,   4'b1111, 4'b1101, 1'b0};
        tbl[6]  = '{2, 1'b1, 4'b0010, 4'b0000, 36'h0AA, 4'b1101, 4'b1101, 1'b0};
        tbl[7]  = '{2, 1'b1, 4'b0010, 4'b0000, 36'h0B0, 4'b1101, 4'b1101, CHK};
        tbl[8]  = '{0, 1'b0, 4'b0000, 4'b1000, 36'h0,   4'b1111, 4'b1111, CHK};
        tbl[9]  = '{1, 1'b1, 4'b0000, 4'b0000, 36'h0C1, 4'b1111, 4'b1111, CHK};
        tbl[10] = '{3, 1'b1, 4'b0101, 4'b0000, 36'hD3,  4'b1111, 4'b1010, CHK};
        tbl[11] = '{4, 1'b0, 4'b1111, 4'b0000, 36'h0E4, 4'b1111, 4'b1111, 1'b0};
        tbl[12] = '{3, 1'b1, 4'b0001, 4'b0001, 36'hD4,  4'b1111, 4'b1010, CHK};

        bus.flit_in_wr_all = '0;
        bus.flit_in_vc_all = '0;
        bus.credit_in_all  = '0;
        bus.flit_in_all    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("reset.avail", bus.credit_avail_all, {P*V{1'b1}});
        chk("reset.full",  bus.credit_full_all,  {P*V{1'b1}});
        chk("reset.wr",    bus.flit_out_wr_all,  '0);
        chk("reset.err",   bus.err_all,          '0);

        for (int k = 0; k < 13; k++) begin
            wr = '0; vc = '0; crd = '0; fl = '0;
            wr[tbl[k].port]             = tbl[k].wr;
            vc[tbl[k].port*V +: V]      = tbl[k].vc;
            crd[tbl[k].port*V +: V]     = tbl[k].crd;
            fl[tbl[k].port*Fw +: Fw]    = tbl[k].flit;
            cycle(wr, vc, crd, fl);
            chk($sformatf("tbl%0d.wr", k),    bus.flit_out_wr_all[tbl[k].port], tbl[k].wr);
            if (tbl[k].wr)
                chk($sformatf("tbl%0d.flit", k), bus.flit_out_all[tbl[k].port*Fw +: Fw], tbl[k].flit);
            chk($sformatf("tbl%0d.avail", k), bus.credit_avail_all[tbl[k].port*V +: V], tbl[k].e_avail);
            chk($sformatf("tbl%0d.full", k),  bus.credit_full_all[tbl[k].port*V +: V],  tbl[k].e_full);
            chk($sformatf("tbl%0d.err", k),   bus.err_all[tbl[k].port], tbl[k].e_err);
            check_all($sformatf("tbl%0d", k));
        end

        // Mid-burst reset on port 4: outputs must clear without waiting for a clock.
        wr = '0; vc = '0; crd = '0; fl = '0;
        wr[4] = 1'b1; vc[4*V] = 1'b1; fl[4*Fw +: Fw] = 36'h4_0000_0001;
        cycle(wr, vc, crd, fl);
        fl[4*Fw +: Fw] = 36'h4_0000_0002;
        cycle(wr, vc, crd, fl);
        chk("burst.wr4", bus.flit_out_wr_all[4], 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("rst.wr",    bus.flit_out_wr_all,  '0);
        chk("rst.vc",    bus.flit_out_vc_all,  '0);
        chk("rst.flit",  bus.flit_out_all,     '0);
        chk("rst.avail", bus.credit_avail_all, {P*V{1'b1}});
        chk("rst.full",  bus.credit_full_all,  {P*V{1'b1}});
        chk("rst.err",   bus.err_all,          '0);
        bus.flit_in_wr_all = '0;
        bus.flit_in_vc_all = '0;
        @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
        #1;
        check_all("post_rst");

        for (int n = 0; n < 300; n++) begin
            for (int p = 0; p < P; p++) begin
                wr[p] = $urandom_range(0, 1);
                if ($urandom_range(0, 9) < 8) vc[p*V +: V] = 4'(1 << $urandom_range(0, V - 1));
                else                          vc[p*V +: V] = 4'($urandom);
                for (int v = 0; v < V; v++) crd[p*V+v] = ($urandom_range(0, 3) == 0);
                r = {$urandom(), $urandom()};
                fl[p*Fw +: Fw] = r[Fw-1:0];
            end
            cycle(wr, vc, crd, fl);
            check_all($sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
